// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multicycle MIPS memory responder.
package mips_mem_pkg;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;
   localparam logic [WORD_W-1:0] ERR_DATA = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/mips_mem_array.sv
// Single-port word array: synchronous write, registered read, no reset on contents.
module mips_mem_array
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = 6
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);
   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      if (i_re) r_q <= r_mem[i_idx];
   end

   assign o_rdata = r_q;
endmodule

// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory slave with req/ready handshake and fixed wait states.
//   state | meaning
//   IDLE  | waiting for req; captures addr/we/wdata when req=1
//   WAIT  | counting down wait states; access performed when cnt reaches 0
//   RESP  | ready (and err) high for exactly one cycle
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              ready,
   output logic              err,
   output logic              busy
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
   localparam logic [29:0]      DEPTH_L   = 30'(DEPTH_WORDS);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic              r_ready;
   logic              r_err;
   logic              r_busy;
   logic              r_rd_zero;

   logic              w_err_c;
   logic              w_access;
   logic              w_arr_we;
   logic              w_arr_re;
   logic [IDX_W-1:0]  w_idx;
   logic [WORD_W-1:0] w_arr_q;

   assign w_err_c  = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= DEPTH_L);
   assign w_access = (r_state == WAIT) && (r_cnt == '0);
   assign w_arr_we = w_access && r_we && !w_err_c;
   assign w_arr_re = w_access && !r_we && !w_err_c;
   assign w_idx    = r_addr[IDX_W+1:2];

   mips_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .i_we    (w_arr_we),
      .i_re    (w_arr_re),
      .i_idx   (w_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_arr_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_ready   <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_rd_zero <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               if (req) begin
                  r_we    <= we;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cnt   <= WAIT_INIT;
                  r_busy  <= 1'b1;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= RESP;
                  r_ready <= 1'b1;
                  r_err   <= w_err_c;
                  // writes leave the read-data path untouched
                  if (!r_we) r_rd_zero <= w_err_c;
               end
            end
            RESP: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Array output only moves on a good read, so it doubles as the held rdata.
   assign rdata = r_rd_zero ? ERR_DATA : w_arr_q;
   assign ready = r_ready;
   assign err   = r_err;
   assign busy  = r_busy;
endmodule
